// File: rtl/switch_debounce_3ch_pkg.sv
// Shared constants for the three-channel switch debouncer.
// Channel indices fix the bit order of the rise/fall vectors.
package switch_debounce_3ch_pkg;

    localparam int NUM_CH             = 3;
    localparam int DB_CNT_MAX_DEFAULT = 1_000_000;
    localparam int DB_CNT_MAX_SIM     = 8;

    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_C = 2;

endpackage

// File: rtl/switch_debounce_3ch_debounce_channel.sv
// One debounced input: 2-flop synchroniser, stability counter, registered level and edge pulses.
// The level only moves after the synchronised input has disagreed with it for DB_CNT_MAX edges.
module debounce_channel
    import switch_debounce_3ch_pkg::*;
#(
    parameter int DB_CNT_MAX = DB_CNT_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic lvl,
    output logic rise,
    output logic fall,
    output logic flip
);

    localparam int                 CNT_W    = $clog2(DB_CNT_MAX);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CNT_MAX - 1);

    logic             meta;
    logic             s;
    logic [CNT_W-1:0] cnt;

    // Exposed so the top can register any_change in the same cycle as rise/fall.
    assign flip = (s != lvl) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            s    <= 1'b0;
            cnt  <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= key;
            s    <= meta;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == lvl) begin
                cnt <= '0;
            end else if (flip) begin
                lvl  <= s;
                cnt  <= '0;
                rise <= s;
                fall <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_debounce_3ch.sv
// Three independent debounced switch inputs with per-channel edge pulses.
// any_change is registered from the channels' flip conditions so it lines up with rise/fall.
module switch_debounce_3ch
    import switch_debounce_3ch_pkg::*;
#(
    parameter int DB_CNT_MAX = DB_CNT_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_a,
    input  logic              key_b,
    input  logic              key_c,
    output logic              da,
    output logic              db,
    output logic              dc,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              any_change
);

    logic [NUM_CH-1:0] keys;
    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] flip;

    assign keys[CH_A] = key_a;
    assign keys[CH_B] = key_b;
    assign keys[CH_C] = key_c;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DB_CNT_MAX(DB_CNT_MAX)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .key  (keys[i]),
            .lvl  (lvl[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .flip (flip[i])
        );
    end

    assign da = lvl[CH_A];
    assign db = lvl[CH_B];
    assign dc = lvl[CH_C];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |flip;
        end
    end

endmodule

// File: tb/tb_switch_debounce_3ch.sv
// Self-checking bench: a sliding-window model of the debounce rule checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized bounce phase.
module tb_switch_debounce_3ch;
    import switch_debounce_3ch_pkg::*;

    localparam int DB = DB_CNT_MAX_SIM;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_a, key_b, key_c;
    logic       da, db, dc;
    logic [2:0] rise, fall;
    logic       any_change;

    int n_checks = 0;
    int n_pass   = 0;

    switch_debounce_3ch #(.DB_CNT_MAX(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_a     (key_a),
        .key_b     (key_b),
        .key_c     (key_c),
        .da        (da),
        .db        (db),
        .dc        (dc),
        .rise      (rise),
        .fall      (fall),
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    // Model: the synchronised value seen at an edge is the raw key sampled two edges earlier;
    // a level flips when the last DB synchronised samples all disagree with it.
    bit       raw_q [3][2];
    bit       s_win [3][DB];
    bit       m_lvl [3];
    bit [2:0] m_rise, m_fall;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            raw_q[c][0] = 1'b0;
            raw_q[c][1] = 1'b0;
            for (int i = 0; i < DB; i++) s_win[c][i] = 1'b0;
            m_lvl[c] = 1'b0;
        end
        m_rise = '0;
        m_fall = '0;
    endtask

    task automatic model_step();
        bit [2:0] k;
        bit       all_diff;
        k = {key_c, key_b, key_a};
        for (int c = 0; c < 3; c++) begin
            for (int i = DB - 1; i > 0; i--) s_win[c][i] = s_win[c][i-1];
            s_win[c][0] = raw_q[c][1];
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++)
                if (s_win[c][i] == m_lvl[c]) all_diff = 1'b0;
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (all_diff) begin
                m_lvl[c]  = ~m_lvl[c];
                m_rise[c] = m_lvl[c];
                m_fall[c] = ~m_lvl[c];
            end
            raw_q[c][1] = raw_q[c][0];
            raw_q[c][0] = k[c];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison, one time unit after the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check_output("model_outputs",
                         {22'd0, da, db, dc, rise, fall, any_change},
                         {22'd0, m_lvl[0], m_lvl[1], m_lvl[2], m_rise, m_fall,
                          |(m_rise | m_fall)});
        end
    end

    // Stimulus and literal checks happen at negedge+2, clear of both the compare and posedge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    function automatic logic [9:0] outs();
        return {da, db, dc, rise, fall, any_change};
    endfunction

    int hold [3];
    bit [2:0] rk;

    initial begin
        rst_n = 1'b0;
        key_a = 1'b1; key_b = 1'b1; key_c = 1'b1;

        // Reset with keys high: outputs stay 0, then all rise together at edge 10.
        tick(3);
        check_output("reset_outputs_zero", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        tick(9);
        check_output("reset_edge9_levels", 32'({da, db, dc}), 32'b000);
        tick(1);
        check_output("reset_edge10_levels", 32'({da, db, dc}), 32'b111);
        check_output("reset_edge10_rise", 32'(rise), 32'b111);
        check_output("reset_edge10_any", 32'(any_change), 32'd1);
        tick(1);
        check_output("reset_pulse_one_cycle", 32'({rise, fall, any_change}), 32'd0);

        // Bring everything low, then a clean press on key_a.
        key_a = 1'b0; key_b = 1'b0; key_c = 1'b0;
        tick(12);
        key_a = 1'b1;
        tick(9);
        check_output("press_edge8_da", 32'(da), 32'd0);
        tick(1);
        check_output("press_edge9", 32'(outs()), 32'({3'b100, 3'b001, 3'b000, 1'b1}));
        tick(1);
        check_output("press_pulse_one_cycle", 32'(rise), 32'd0);

        // Bounce train on key_b: only the final 0->1 starts a completed window.
        for (int b = 0; b < 4; b++) begin
            key_b = (b % 2 == 0);
            tick(3);
            check_output("bounce_db_low", 32'(db), 32'd0);
        end
        key_b = 1'b1;
        tick(9);
        check_output("bounce_edge8_db", 32'(db), 32'd0);
        tick(1);
        check_output("bounce_edge9", 32'({db, rise}), 32'({1'b1, 3'b010}));

        // Short glitch on key_c: 7 cycles low must not drop dc, 8 cycles must.
        key_c = 1'b1;
        tick(12);
        key_c = 1'b0;
        tick(7);
        key_c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_output("glitch7_dc_held", 32'({dc, fall[2]}), 32'b10);
        end
        key_c = 1'b0;
        tick(8);
        key_c = 1'b1;
        tick(2);
        check_output("glitch8_fall", 32'({dc, fall}), 32'({1'b0, 3'b100}));
        tick(12);

        // Simultaneous flips: key_a 1->0 and key_c 0->1 on the same edge.
        key_c = 1'b0;
        tick(12);
        key_a = 1'b0;
        key_c = 1'b1;
        tick(10);
        check_output("simul_pulses", 32'({rise, fall, any_change}),
                     32'({3'b100, 3'b001, 1'b1}));
        tick(1);
        check_output("simul_any_one_cycle", 32'(any_change), 32'd0);

        // Async reset mid-count: outputs clear between edges, no early pulse afterwards.
        key_b = 1'b0;
        tick(5);
        rst_n = 1'b0;
        #1;
        check_output("async_reset_immediate", 32'(outs()), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(9);
        check_output("post_reset_edge9", 32'(outs()), 32'd0);
        tick(1);
        check_output("post_reset_edge10", 32'({dc, rise}), 32'({1'b1, 3'b100}));

        // Random bounce phase with occasional async reset pulses.
        for (int c = 0; c < 3; c++) hold[c] = 0;
        for (int t = 0; t < 2000; t++) begin
            rk = {key_c, key_b, key_a};
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    rk[c]   = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 14);
                end else begin
                    hold[c]--;
                end
            end
            {key_c, key_b, key_a} = rk;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            tick(1);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
